// File: rtl/tx_backoff_scheduler_pkg.sv
// Shared xpu definitions for the tx backoff scheduler: FSM states and CW exponent width.
package tx_backoff_scheduler_pkg;

    localparam int unsigned CW_W = 4;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SELECT      = 3'd1,
        BACKOFF     = 3'd2,
        WAIT_RESULT = 3'd3,
        UPDATE      = 3'd4
    } state_t;

endpackage

// File: rtl/tx_backoff_scheduler_prio_enc_onehot.sv
// Combinational highest-set-bit encoder with a valid flag.
module prio_enc_onehot #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Ascending scan: the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_backoff_scheduler.sv
// Sequences the CSMA/CA backoff engine across transmit queues, tracking per-queue CW and retries.
module tx_backoff_scheduler
    import tx_backoff_scheduler_pkg::*;
#(
    parameter int unsigned NUM_QUEUE      = 4,
    parameter int unsigned QW             = 2,
    parameter logic [15:0] RESULT_TIMEOUT = 16'd40000,
    parameter int unsigned SETTLE_CYCLES  = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_QUEUE-1:0] queue_pending,
    input  logic [CW_W-1:0]      cw_min_exp,
    input  logic [CW_W-1:0]      cw_max_exp,
    input  logic [3:0]           retry_limit,
    input  logic                 backoff_done,
    input  logic                 tx_end,
    input  logic                 tx_success,
    output logic [CW_W-1:0]      cw_exp,
    output logic                 tx_start,
    output logic [QW-1:0]        tx_queue,
    output logic                 drop_pulse,
    output logic [QW-1:0]        drop_queue,
    output logic                 busy
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 2);

    state_t              state, state_next;
    logic [QW-1:0]       sel;
    logic [SW-1:0]       settle_cnt;
    logic [15:0]         to_cnt;
    logic                result_ok;
    logic [CW_W-1:0]     cw_q    [NUM_QUEUE];
    logic [3:0]          retry_q [NUM_QUEUE];

    logic [QW-1:0]       pend_idx;
    logic                pend_valid;
    logic                settled;
    logic                timed_out;
    logic                grant;
    logic [4:0]          retry_inc;
    logic [CW_W:0]       cw_inc;
    logic [CW_W-1:0]     cw_ceiling;
    logic [CW_W-1:0]     cw_sat;
    logic                drop_now;

    prio_enc_onehot #(
        .N (NUM_QUEUE),
        .W (QW)
    ) u_prio (
        .req   (queue_pending),
        .idx   (pend_idx),
        .valid (pend_valid)
    );

    assign settled   = (settle_cnt == SW'(SETTLE_CYCLES));
    assign timed_out = (to_cnt == RESULT_TIMEOUT - 16'd1);
    assign busy      = (state != IDLE);

    // Failure bookkeeping: 5-bit retry compare, CW ceiling never below cw_min_exp.
    always_comb begin
        retry_inc  = {1'b0, retry_q[sel]} + 5'd1;
        cw_inc     = {1'b0, cw_q[sel]} + 5'd1;
        cw_ceiling = (cw_max_exp < cw_min_exp) ? cw_min_exp : cw_max_exp;
        cw_sat     = (cw_inc > {1'b0, cw_ceiling}) ? cw_ceiling : cw_inc[CW_W-1:0];
        drop_now   = !result_ok && (retry_inc > {1'b0, retry_limit});
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        unique case (state)
            IDLE:        if (pend_valid) state_next = SELECT;
            SELECT:      state_next = BACKOFF;
            BACKOFF: begin
                if (!queue_pending[sel]) begin
                    state_next = IDLE;
                end else if (settled && backoff_done) begin
                    grant      = 1'b1;
                    state_next = WAIT_RESULT;
                end
            end
            WAIT_RESULT: if (tx_end || timed_out) state_next = UPDATE;
            UPDATE:      state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sel        <= '0;
            settle_cnt <= '0;
            to_cnt     <= '0;
            result_ok  <= 1'b0;
            cw_exp     <= '0;
            tx_start   <= 1'b0;
            tx_queue   <= '0;
            drop_pulse <= 1'b0;
            drop_queue <= '0;
            for (int unsigned i = 0; i < NUM_QUEUE; i++) begin
                cw_q[i]    <= '0;
                retry_q[i] <= '0;
            end
        end else begin
            tx_start   <= grant;
            drop_pulse <= 1'b0;
            unique case (state)
                IDLE: if (pend_valid) sel <= pend_idx;
                SELECT: begin
                    settle_cnt <= '0;
                    if (retry_q[sel] == 4'd0) begin
                        cw_exp    <= cw_min_exp;
                        cw_q[sel] <= cw_min_exp;
                    end else begin
                        cw_exp <= cw_q[sel];
                    end
                end
                BACKOFF: begin
                    if (!settled) settle_cnt <= settle_cnt + 1'b1;
                    if (grant) begin
                        tx_queue <= sel;
                        to_cnt   <= '0;
                    end
                end
                WAIT_RESULT: begin
                    // tx_end takes precedence over a simultaneous timeout.
                    if (tx_end)         result_ok <= tx_success;
                    else if (timed_out) result_ok <= 1'b0;
                    else                to_cnt    <= to_cnt + 16'd1;
                end
                UPDATE: begin
                    if (result_ok || drop_now) begin
                        retry_q[sel] <= '0;
                        cw_q[sel]    <= cw_min_exp;
                    end else begin
                        retry_q[sel] <= retry_inc[3:0];
                        cw_q[sel]    <= cw_sat;
                    end
                    if (drop_now) begin
                        drop_pulse <= 1'b1;
                        drop_queue <= sel;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_backoff_scheduler.sv
// Self-checking bench: constant vector table, hand-written corner sequences, random traffic vs a transaction model.
module tb_tx_backoff_scheduler;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] queue_pending = '0;
    logic [3:0] cw_min_exp = '0;
    logic [3:0] cw_max_exp = '0;
    logic [3:0] retry_limit = '0;
    logic       backoff_done = 1'b1;
    logic       tx_end = 1'b0;
    logic       tx_success = 1'b0;
    logic [3:0] cw_exp;
    logic       tx_start;
    logic [1:0] tx_queue;
    logic       drop_pulse;
    logic [1:0] drop_queue;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int m_cw[4];
    int m_retry[4];

    tx_backoff_scheduler #(
        .NUM_QUEUE      (4),
        .QW             (2),
        .RESULT_TIMEOUT (16'd30),
        .SETTLE_CYCLES  (2)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .queue_pending (queue_pending),
        .cw_min_exp    (cw_min_exp),
        .cw_max_exp    (cw_max_exp),
        .retry_limit   (retry_limit),
        .backoff_done  (backoff_done),
        .tx_end        (tx_end),
        .tx_success    (tx_success),
        .cw_exp        (cw_exp),
        .tx_start      (tx_start),
        .tx_queue      (tx_queue),
        .drop_pulse    (drop_pulse),
        .drop_queue    (drop_queue),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    function automatic int top_bit(input logic [3:0] p);
        for (int i = 3; i >= 0; i--) if (p[i]) return i;
        return 0;
    endfunction

    function automatic int exp_cw(input int q, input int cmin);
        return (m_retry[q] == 0) ? cmin : m_cw[q];
    endfunction

    function automatic bit exp_drop(input int q, input bit succ, input int lim);
        return !succ && (m_retry[q] + 1 > lim);
    endfunction

    task automatic m_load(input int q, input int cmin);
        if (m_retry[q] == 0) m_cw[q] = cmin;
    endtask

    task automatic m_result(input int q, input bit succ, input int cmin, input int cmax, input int lim);
        int ceil_v;
        ceil_v = (cmax > cmin) ? cmax : cmin;
        if (succ || (m_retry[q] + 1 > lim)) begin
            m_retry[q] = 0;
            m_cw[q]    = cmin;
        end else begin
            m_retry[q] = m_retry[q] + 1;
            m_cw[q]    = (m_cw[q] + 1 > ceil_v) ? ceil_v : m_cw[q] + 1;
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 4; i++) begin
            m_cw[i]    = 0;
            m_retry[i] = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        bit seen;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_timeout", 32'(seen), 32'd1);
    endtask

    task automatic grant(input logic [3:0] pend, input int bo, output logic ok,
                         output logic [1:0] gq, output logic [3:0] gcw, output int lat);
        ok  = 1'b0;
        gq  = '0;
        gcw = '0;
        lat = 0;
        backoff_done  = (bo == 0);
        queue_pending = pend;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i + 1 == bo) backoff_done = 1'b1;
            if (tx_start) begin
                ok  = 1'b1;
                gq  = tx_queue;
                gcw = cw_exp;
                lat = i + 1;
                break;
            end
        end
        backoff_done  = 1'b1;
        queue_pending = '0;
        chk("grant_timeout", 32'(ok), 32'd1);
        @(negedge clk);
        chk("tx_start_width", 32'(tx_start), 32'd0);
    endtask

    task automatic txn(input logic [3:0] pend, input logic [3:0] cmin, input logic [3:0] cmax,
                       input logic [3:0] lim, input logic succ, input int dly, input int bo,
                       output logic [1:0] gq, output logic [3:0] gcw, output logic gdrop,
                       output logic [1:0] gdq, output int lat);
        logic ok;
        int   q;
        cw_min_exp  = cmin;
        cw_max_exp  = cmax;
        retry_limit = lim;
        gdrop = 1'b0;
        gdq   = '0;
        q = top_bit(pend);
        wait_idle();
        grant(pend, bo, ok, gq, gcw, lat);
        if (!ok) return;
        m_load(q, int'(cmin));
        repeat (dly) @(negedge clk);
        chk("tx_queue_hold", 32'(tx_queue), 32'(gq));
        tx_end     = 1'b1;
        tx_success = succ;
        @(negedge clk);
        tx_end     = 1'b0;
        tx_success = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (drop_pulse) begin
                gdrop = 1'b1;
                gdq   = drop_queue;
            end
        end
        m_result(q, succ, int'(cmin), int'(cmax), int'(lim));
    endtask

    typedef struct {
        logic [3:0] pend;
        logic [3:0] cmin;
        logic [3:0] cmax;
        logic [3:0] lim;
        logic       succ;
        logic [1:0] eq;
        logic [3:0] ecw;
        logic       edrop;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [1:0] gq, gdq;
        logic [3:0] gcw;
        logic       gdrop, ok;
        int         lat, q, ecw, tcount;
        bit         edr;
        logic [3:0] pend, cmin, cmax, lim;
        logic       succ;

        tbl[0]  = '{4'b0101, 4'd4, 4'd8, 4'd7, 1'b1, 2'd2, 4'd4, 1'b0};
        tbl[1]  = '{4'b0010, 4'd3, 4'd5, 4'd7, 1'b0, 2'd1, 4'd3, 1'b0};
        tbl[2]  = '{4'b0010, 4'd3, 4'd5, 4'd7, 1'b0, 2'd1, 4'd4, 1'b0};
        tbl[3]  = '{4'b0010, 4'd3, 4'd5, 4'd7, 1'b0, 2'd1, 4'd5, 1'b0};
        tbl[4]  = '{4'b0010, 4'd3, 4'd5, 4'd7, 1'b1, 2'd1, 4'd5, 1'b0};
        tbl[5]  = '{4'b1000, 4'd2, 4'd6, 4'd2, 1'b0, 2'd3, 4'd2, 1'b0};
        tbl[6]  = '{4'b1000, 4'd2, 4'd6, 4'd2, 1'b0, 2'd3, 4'd3, 1'b0};
        tbl[7]  = '{4'b1000, 4'd2, 4'd6, 4'd2, 1'b0, 2'd3, 4'd4, 1'b1};
        tbl[8]  = '{4'b1000, 4'd2, 4'd6, 4'd2, 1'b1, 2'd3, 4'd2, 1'b0};
        tbl[9]  = '{4'b1111, 4'd6, 4'd3, 4'd1, 1'b0, 2'd3, 4'd6, 1'b0};
        tbl[10] = '{4'b1111, 4'd6, 4'd3, 4'd1, 1'b0, 2'd3, 4'd6, 1'b1};
        m_clear();

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_cw_exp", 32'(cw_exp), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_queue", 32'(tx_queue), 32'd0);
        chk("rst_drop_pulse", 32'(drop_pulse), 32'd0);
        chk("rst_drop_queue", 32'(drop_queue), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // constant vector table
        for (int i = 0; i < 11; i++) begin
            txn(tbl[i].pend, tbl[i].cmin, tbl[i].cmax, tbl[i].lim, tbl[i].succ, i % 3, 0,
                gq, gcw, gdrop, gdq, lat);
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'd5);
            chk($sformatf("tbl%0d_queue", i), 32'(gq), 32'(tbl[i].eq));
            chk($sformatf("tbl%0d_cw", i), 32'(gcw), 32'(tbl[i].ecw));
            chk($sformatf("tbl%0d_drop", i), 32'(gdrop), 32'(tbl[i].edrop));
            if (tbl[i].edrop) chk($sformatf("tbl%0d_drop_queue", i), 32'(gdq), 32'(tbl[i].eq));
        end

        // result timeout counts as a failure
        cw_min_exp = 4'd2; cw_max_exp = 4'd8; retry_limit = 4'd5;
        wait_idle();
        q = 0;
        ecw = exp_cw(q, 2);
        grant(4'b0001, 0, ok, gq, gcw, lat);
        chk("to_grant_cw", 32'(gcw), 32'(ecw));
        m_load(q, 2);
        repeat (20) @(negedge clk);
        chk("to_still_waiting", 32'(busy), 32'd1);
        wait_idle();
        m_result(q, 1'b0, 2, 8, 5);
        ecw = exp_cw(q, 2);
        txn(4'b0001, 4'd2, 4'd8, 4'd5, 1'b1, 1, 0, gq, gcw, gdrop, gdq, lat);
        chk("to_next_cw", 32'(gcw), 32'(ecw));
        chk("to_next_cw_value", 32'(gcw), 32'd3);
        chk("to_no_drop", 32'(gdrop), 32'd0);

        // abort in BACKOFF leaves per-queue state untouched
        txn(4'b0010, 4'd3, 4'd6, 4'd5, 1'b0, 0, 0, gq, gcw, gdrop, gdq, lat);
        wait_idle();
        tcount = 0;
        backoff_done  = 1'b0;
        queue_pending = 4'b0010;
        repeat (6) begin
            @(negedge clk);
            if (tx_start) tcount++;
        end
        chk("abort_busy_in_backoff", 32'(busy), 32'd1);
        queue_pending = '0;
        repeat (3) begin
            @(negedge clk);
            if (tx_start) tcount++;
        end
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_no_tx_start", 32'(tcount), 32'd0);
        backoff_done = 1'b1;
        ecw = exp_cw(1, 3);
        txn(4'b0010, 4'd3, 4'd6, 4'd5, 1'b1, 0, 0, gq, gcw, gdrop, gdq, lat);
        chk("abort_next_cw", 32'(gcw), 32'(ecw));
        chk("abort_next_cw_value", 32'(gcw), 32'd4);

        // reset during WAIT_RESULT forgets the granted frame
        txn(4'b0100, 4'd1, 4'd8, 4'd5, 1'b0, 0, 0, gq, gcw, gdrop, gdq, lat);
        wait_idle();
        grant(4'b0100, 0, ok, gq, gcw, lat);
        chk("rstmid_grant_cw", 32'(gcw), 32'd2);
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        m_clear();
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_cw_exp", 32'(cw_exp), 32'd0);
        chk("rstmid_tx_queue", 32'(tx_queue), 32'd0);
        chk("rstmid_tx_start", 32'(tx_start), 32'd0);
        tx_end = 1'b1; tx_success = 1'b0;
        @(negedge clk);
        tx_end = 1'b0;
        tcount = 0;
        repeat (4) begin
            @(negedge clk);
            if (drop_pulse || tx_start || busy) tcount++;
        end
        chk("rstmid_quiet_after_tx_end", 32'(tcount), 32'd0);
        txn(4'b0100, 4'd1, 4'd8, 4'd5, 1'b1, 0, 0, gq, gcw, gdrop, gdq, lat);
        chk("rstmid_next_cw", 32'(gcw), 32'd1);

        // randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            pend = 4'($urandom_range(1, 15));
            cmin = 4'($urandom_range(0, 8));
            cmax = 4'($urandom_range(0, 8));
            lim  = 4'($urandom_range(0, 3));
            succ = ($urandom_range(0, 2) == 0);
            q    = top_bit(pend);
            ecw  = exp_cw(q, int'(cmin));
            edr  = exp_drop(q, succ, int'(lim));
            txn(pend, cmin, cmax, lim, succ, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                gq, gcw, gdrop, gdq, lat);
            chk($sformatf("rnd%0d_queue", n), 32'(gq), 32'(q));
            chk($sformatf("rnd%0d_cw", n), 32'(gcw), 32'(ecw));
            chk($sformatf("rnd%0d_drop", n), 32'(gdrop), 32'(edr));
            if (edr) chk($sformatf("rnd%0d_drop_queue", n), 32'(gdq), 32'(q));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
